param_counter: RTL and testbench
================================

Name: param_counter

Overview:
Parametrised successor to the team's fixed 8-bit demo counter, used in NovyWave example designs to produce richer waveforms.
- Counts up or down between 0 and a run-time modulus.
- Supports wrap or saturate mode, a synchronous parallel load and an enable prescaler.
- Emits registered overflow, underflow and tick pulses.
- Sits standalone in example tops, driven by a testbench, with all outputs dumped to VCD.

Parameters:
WIDTH, 8, count/modulus/load width in bits (>=2)
PRESCALE_WIDTH, 4, width of prescale divider field (>=1)

Ports:
clk  input  1  single clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
enable  input  1  counting enable; gates the prescaler
up_down  input  1  1 = count up, 0 = count down; sampled on each tick
saturate  input  1  1 = hold at boundary, 0 = wrap at boundary
load  input  1  synchronous parallel load strobe
load_value  input  WIDTH  value loaded when load=1
modulus  input  WIDTH  terminal value; count range is 0..modulus
prescale  input  PRESCALE_WIDTH  one count tick every prescale+1 enabled cycles
count  output  WIDTH  registered counter value
overflow  output  1  registered 1-cycle pulse: up tick at/after terminal value
underflow  output  1  registered 1-cycle pulse: down tick at 0
tick  output  1  registered 1-cycle pulse: count tick occurred this edge
terminal  output  1  combinational: up_down ? (count >= modulus) : (count == 0)

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset. No asynchronous paths.
- Reset (reset=1 at posedge):
  - count=0, overflow=0, underflow=0, tick=0.
  - Internal divider div=0.
  - Reset overrides load and enable.
- Priority per edge: reset > load > enabled tick > hold.
- Load (load=1, reset=0):
  - count = min(load_value, modulus).
  - div=0; overflow/underflow/tick=0 that edge.
  - Load wins over enable in the same cycle.
- Prescaler:
  - enable=0: div holds, no tick, pulse outputs return to 0.
  - enable=1, div >= prescale: tick occurs, div=0.
  - enable=1, otherwise: div = div+1.
  - prescale=0 gives a tick every enabled cycle.
  - prescale lowered below div mid-run: tick on the next enabled cycle (>= comparison).
- Tick, up (up_down=1):
  - count < modulus: count+1.
  - count >= modulus, wrap mode: count=0, overflow=1.
  - count >= modulus, saturate mode: count=modulus, overflow=1.
- Tick, down (up_down=0):
  - count > modulus: count=modulus, no underflow (modulus reduced mid-run).
  - 0 < count <= modulus: count-1.
  - count == 0, wrap mode: count=modulus, underflow=1.
  - count == 0, saturate mode: count=0, underflow=1.
- Pulses:
  - overflow, underflow and tick are high for exactly one cycle, registered on the same edge as the count update.
  - They are low on any edge without a tick.
  - overflow and underflow are never high together.
- modulus=0: count stays 0. Every up tick pulses overflow; every down tick pulses underflow.
- Latency: count changes on the same posedge that consumes the tick. With prescale=P and enable held high from div=0, the first tick lands on the (P+1)th edge.
- Arithmetic: unsigned, WIDTH bits, no carry out. All comparisons are unsigned.
- up_down, saturate, modulus and prescale may change any cycle; they take effect at the next edge.

Test Plan:
- Reset then enable=1, up, WIDTH=8, modulus=255, prescale=0, wrap → count 0,1,...,255,0. overflow pulses exactly once, at the 255→0 edge. tick high every cycle.
- modulus=9, prescale=2, up, wrap, enable=1 for 33 cycles → count increments every 3rd edge: 0..9 then 0. overflow at the 10th tick (cycle 30). tick is a 1-in-3 pulse train.
- Down, saturate, load_value=3, load=1 then enable=1, prescale=0 → count 3,2,1,0,0,0. underflow pulses on each tick at 0 (edges 4, 5, ...). terminal=1 once count=0.
- load=1 with load_value=200, modulus=50 → count=50. Same cycle with enable=1 and div at threshold → no tick, div=0.
- Running up at count=40 with modulus=100: change modulus to 20 → next tick wraps to 0 with overflow=1. In saturate mode → count=20. Down tick from 40 → count=20, no underflow.
- Assert reset mid-count (count=7, div=2) together with load=1 → next edge count=0, all pulses 0, div=0. First tick after release is prescale+1 enabled edges later.

Source files
------------

// File: rtl/param_counter.sv
// param_counter: up/down counter over 0..modulus with wrap or saturate at the
// boundary, a synchronous parallel load and an enable prescaler. The overflow,
// underflow and tick pulses are registered on the same edge as the count update.
// terminal is combinational from the current count and the current direction.
//
// Handshake: there is none. Every input is sampled on each posedge, and the
// outputs reflect the result of that edge.
module param_counter #(
    parameter int WIDTH          = 8,
    parameter int PRESCALE_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      up_down,
    input  logic                      saturate,
    input  logic                      load,
    input  logic [WIDTH-1:0]          load_value,
    input  logic [WIDTH-1:0]          modulus,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic [WIDTH-1:0]          count,
    output logic                      overflow,
    output logic                      underflow,
    output logic                      tick,
    output logic                      terminal
);

    // Prescaler phase. It counts enabled cycles since the last tick.
    logic [PRESCALE_WIDTH-1:0] div;

    // Values produced by a tick, computed from the present count and the inputs.
    logic [WIDTH-1:0] next_count;
    logic             next_overflow;
    logic             next_underflow;
    logic [WIDTH-1:0] load_clamped;
    logic             tick_due;

    // The >= test lets a prescale that drops below div fire on the next enabled cycle.
    assign tick_due = (div >= prescale);

    // A load is clamped into the legal range 0..modulus.
    assign load_clamped = (load_value > modulus) ? modulus : load_value;

    // The boundary is direction dependent: modulus going up, zero going down.
    assign terminal = up_down ? (count >= modulus) : (count == '0);

    // Decide what a tick does to the count and which boundary pulse it raises.
    always_comb begin
        next_count     = count;
        next_overflow  = 1'b0;
        next_underflow = 1'b0;
        if (up_down) begin
            if (count < modulus) begin
                next_count = count + 1'b1;
            end else begin
                // count >= modulus also covers a modulus lowered below the count.
                next_count    = saturate ? modulus : '0;
                next_overflow = 1'b1;
            end
        end else begin
            if (count > modulus) begin
                // The modulus was lowered mid-run. The count snaps back into range
                // without an underflow.
                next_count = modulus;
            end else if (count != '0) begin
                next_count = count - 1'b1;
            end else begin
                next_count     = saturate ? '0 : modulus;
                next_underflow = 1'b1;
            end
        end
    end

    // Priority on each edge: reset, then load, then an enabled tick, then hold.
    // The pulses clear on every edge that has no tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= '0;
            div       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            tick      <= 1'b0;
        end else if (load) begin
            count     <= load_clamped;
            div       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            tick      <= 1'b0;
        end else if (enable && tick_due) begin
            count     <= next_count;
            div       <= '0;
            overflow  <= next_overflow;
            underflow <= next_underflow;
            tick      <= 1'b1;
        end else begin
            if (enable) begin
                div <= div + 1'b1;
            end
            overflow  <= 1'b0;
            underflow <= 1'b0;
            tick      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_param_counter.sv
// Testbench for param_counter with WIDTH=8 and PRESCALE_WIDTH=4. It applies a
// table of directed vectors with hand-computed results, then runs two long
// sequences: a full 0..255 wrap, and a mod-10 count with a divide-by-3 prescaler.
module tb_param_counter;

    localparam int W  = 8;
    localparam int PW = 4;

    // Clock and reset.
    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic          up_down = 1'b1;
    logic          saturate = 1'b0;
    logic          load = 1'b0;
    logic [W-1:0]  load_value = '0;
    logic [W-1:0]  modulus = '0;
    logic [PW-1:0] prescale = '0;
    logic [W-1:0]  count;
    logic          overflow;
    logic          underflow;
    logic          tick;
    logic          terminal;

    always #5 clk = ~clk;

    param_counter #(.WIDTH(W), .PRESCALE_WIDTH(PW)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .up_down    (up_down),
        .saturate   (saturate),
        .load       (load),
        .load_value (load_value),
        .modulus    (modulus),
        .prescale   (prescale),
        .count      (count),
        .overflow   (overflow),
        .underflow  (underflow),
        .tick       (tick),
        .terminal   (terminal)
    );

    typedef struct {
        logic          rst;
        logic          en;
        logic          ud;
        logic          sat;
        logic          ld;
        logic [W-1:0]  lv;
        logic [W-1:0]  md;
        logic [PW-1:0] ps;
        logic [W-1:0]  exp_count;
        logic          exp_ov;
        logic          exp_un;
        logic          exp_tick;
        logic          exp_term;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   ov_seen;

    // Scoreboard comparison.
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void add(input int rst, input int en, input int ud, input int sat,
                                input int ld, input int lv, input int md, input int ps,
                                input int c, input int ov, input int un, input int tk,
                                input int tm);
        vec_t v;
        v.rst = rst[0]; v.en = en[0]; v.ud = ud[0]; v.sat = sat[0]; v.ld = ld[0];
        v.lv = lv[W-1:0]; v.md = md[W-1:0]; v.ps = ps[PW-1:0];
        v.exp_count = c[W-1:0]; v.exp_ov = ov[0]; v.exp_un = un[0];
        v.exp_tick = tk[0]; v.exp_term = tm[0];
        vecs.push_back(v);
    endfunction

    // Driver: hold the inputs across one posedge, then sample 1 time unit later.
    task automatic drive(input logic rst, input logic en, input logic ud, input logic sat,
                         input logic ld, input logic [W-1:0] lv, input logic [W-1:0] md,
                         input logic [PW-1:0] ps);
        reset = rst; enable = en; up_down = ud; saturate = sat; load = ld;
        load_value = lv; modulus = md; prescale = ps;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //   rst en ud sat ld  lv  mod ps   cnt ov un tk term
        add(1, 1, 1, 0, 1,   5,  10, 0,    0, 0, 0, 0, 0); // 0 reset beats load and enable
        add(0, 1, 0, 1, 1,   3,  10, 0,    3, 0, 0, 0, 0); // 1 load beats enable
        add(0, 1, 0, 1, 0,   0,  10, 0,    2, 0, 0, 1, 0); // 2 down
        add(0, 1, 0, 1, 0,   0,  10, 0,    1, 0, 0, 1, 0); // 3
        add(0, 1, 0, 1, 0,   0,  10, 0,    0, 0, 0, 1, 1); // 4 reaches 0, no underflow yet
        add(0, 1, 0, 1, 0,   0,  10, 0,    0, 0, 1, 1, 1); // 5 saturate at 0, underflow
        add(0, 1, 0, 1, 0,   0,  10, 0,    0, 0, 1, 1, 1); // 6
        add(0, 0, 0, 1, 0,   0,  10, 0,    0, 0, 0, 0, 1); // 7 disabled, pulses clear
        add(0, 1, 1, 0, 1, 200,  50, 0,   50, 0, 0, 0, 1); // 8 load clamps to modulus
        add(0, 1, 1, 0, 0,   0,  50, 0,    0, 1, 0, 1, 0); // 9 wrap at modulus
        add(0, 1, 1, 0, 0,   0,  50, 0,    1, 0, 0, 1, 0); // 10
        add(0, 1, 1, 0, 0,   0,   0, 0,    0, 1, 0, 1, 1); // 11 modulus 0, above range
        add(0, 1, 1, 0, 0,   0,   0, 0,    0, 1, 0, 1, 1); // 12 modulus 0, up tick
        add(0, 1, 0, 0, 0,   0,   0, 0,    0, 0, 1, 1, 1); // 13 modulus 0, down tick
        add(0, 0, 1, 0, 1,  40, 100, 0,   40, 0, 0, 0, 0); // 14
        add(0, 1, 1, 0, 0,   0,  20, 0,    0, 1, 0, 1, 0); // 15 modulus dropped, wrap
        add(0, 0, 1, 0, 1,  40, 100, 0,   40, 0, 0, 0, 0); // 16
        add(0, 1, 1, 1, 0,   0,  20, 0,   20, 1, 0, 1, 1); // 17 modulus dropped, saturate
        add(0, 0, 1, 0, 1,  40, 100, 0,   40, 0, 0, 0, 0); // 18
        add(0, 1, 0, 0, 0,   0,  20, 0,   20, 0, 0, 1, 0); // 19 down snaps to modulus
        add(0, 0, 1, 0, 1,   0, 100, 2,    0, 0, 0, 0, 0); // 20
        add(0, 1, 1, 0, 0,   0, 100, 2,    0, 0, 0, 0, 0); // 21 div 0->1
        add(0, 1, 1, 0, 0,   0, 100, 2,    0, 0, 0, 0, 0); // 22 div 1->2
        add(0, 1, 1, 0, 1, 200,  50, 2,   50, 0, 0, 0, 1); // 23 load while div at threshold
        add(0, 1, 1, 0, 0,   0, 100, 2,   50, 0, 0, 0, 0); // 24 div was cleared
        add(0, 1, 1, 0, 0,   0, 100, 2,   50, 0, 0, 0, 0); // 25
        add(0, 1, 1, 0, 0,   0, 100, 2,   51, 0, 0, 1, 0); // 26 tick on the 3rd edge
        add(0, 1, 1, 0, 0,   0, 100, 3,   51, 0, 0, 0, 0); // 27 div 0->1
        add(0, 1, 1, 0, 0,   0, 100, 3,   51, 0, 0, 0, 0); // 28 div 1->2
        add(0, 1, 1, 0, 0,   0, 100, 0,   52, 0, 0, 1, 0); // 29 prescale lowered below div
        add(0, 1, 1, 0, 0,   0, 100, 3,   52, 0, 0, 0, 0); // 30
        add(0, 1, 1, 0, 0,   0, 100, 3,   52, 0, 0, 0, 0); // 31 div=2
        add(1, 1, 1, 0, 1,   9, 100, 3,    0, 0, 0, 0, 0); // 32 reset mid-count with load
        add(0, 1, 1, 0, 0,   0, 100, 2,    0, 0, 0, 0, 0); // 33 div 0->1
        add(0, 0, 1, 0, 0,   0, 100, 2,    0, 0, 0, 0, 0); // 34 div holds
        add(0, 1, 1, 0, 0,   0, 100, 2,    0, 0, 0, 0, 0); // 35 div 1->2
        add(0, 1, 1, 0, 0,   0, 100, 2,    1, 0, 0, 1, 0); // 36 first tick after reset

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].ud, vecs[i].sat, vecs[i].ld,
                  vecs[i].lv, vecs[i].md, vecs[i].ps);
            check($sformatf("v%0d count", i),     32'(count),     32'(vecs[i].exp_count));
            check($sformatf("v%0d overflow", i),  32'(overflow),  32'(vecs[i].exp_ov));
            check($sformatf("v%0d underflow", i), 32'(underflow), 32'(vecs[i].exp_un));
            check($sformatf("v%0d tick", i),      32'(tick),      32'(vecs[i].exp_tick));
            check($sformatf("v%0d terminal", i),  32'(terminal),  32'(vecs[i].exp_term));
        end

        // Full-range wrap: modulus 255, prescale 0, up, wrap mode.
        drive(1, 0, 1, 0, 0, 8'd0, 8'd255, 4'd0);
        check("full reset count", 32'(count), 32'd0);
        ov_seen = 0;
        for (int i = 1; i <= 256; i++) begin
            drive(0, 1, 1, 0, 0, 8'd0, 8'd255, 4'd0);
            if (overflow) ov_seen++;
            check($sformatf("full e%0d count", i), 32'(count), 32'(i % 256));
            check($sformatf("full e%0d tick", i), 32'(tick), 32'd1);
            check($sformatf("full e%0d overflow", i), 32'(overflow), (i == 256) ? 32'd1 : 32'd0);
        end
        check("full overflow total", 32'(ov_seen), 32'd1);

        // Modulus 9 with prescale 2: one tick every 3rd edge, overflow at edge 30.
        drive(1, 0, 1, 0, 0, 8'd0, 8'd9, 4'd2);
        for (int k = 1; k <= 33; k++) begin
            drive(0, 1, 1, 0, 0, 8'd0, 8'd9, 4'd2);
            check($sformatf("mod10 e%0d count", k), 32'(count), 32'((k / 3) % 10));
            check($sformatf("mod10 e%0d tick", k), 32'(tick), (k % 3 == 0) ? 32'd1 : 32'd0);
            check($sformatf("mod10 e%0d overflow", k), 32'(overflow), (k == 30) ? 32'd1 : 32'd0);
            check($sformatf("mod10 e%0d underflow", k), 32'(underflow), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
